// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronises rxd, frames start/data/parity/stop bits on
// the prescaler's mid-bit strobe and presents each character on an AXI-Stream port.
module uart_rx_sequencer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 prs_en,
  input  logic                 prs_half,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [1:0]           m_axis_tuser,
  output logic                 overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e               state_q;
  logic                 rxd_meta_q, rxd_s_q, rxd_hist_q;
  logic                 prs_en_q;
  logic [2:0]           cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic [DATA_BITS-1:0] tdata_q;
  logic                 tvalid_q;
  logic [1:0]           tuser_q;
  logic                 overrun_q;

  logic                 fall;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_xor;
  logic                 par_err_d;
  logic                 accept;

  // Synchroniser flops reset high so a line idling high never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_hist_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_hist_q <= rxd_s_q;
    end
  end

  assign fall      = rxd_hist_q & ~rxd_s_q;
  assign shift_d   = {rxd_s_q, shift_q[DATA_BITS-1:1]};
  assign par_xor   = (^shift_q) ^ rxd_s_q;
  assign par_err_d = (PARITY == 1) ? ~par_xor : par_xor;
  assign accept    = ~tvalid_q | m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prs_en_q  <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tuser_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q   <= START;
            prs_en_q  <= 1'b1;
            par_err_q <= 1'b0;
          end
        end
        START: begin
          if (prs_half) begin
            if (rxd_s_q) begin
              state_q  <= IDLE;
              prs_en_q <= 1'b0;
            end else begin
              cnt_q   <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (prs_half) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == LAST_BIT) begin
              state_q <= (PARITY != 0) ? PAR : STOP;
            end
          end
        end
        PAR: begin
          if (prs_half) begin
            par_err_q <= par_err_d;
            state_q   <= STOP;
          end
        end
        STOP: begin
          // Dropping prs_en here re-phases the prescaler on the next start edge.
          if (prs_half) begin
            state_q  <= IDLE;
            prs_en_q <= 1'b0;
            if (accept) begin
              tvalid_q <= 1'b1;
              tdata_q  <= shift_q;
              tuser_q  <= {par_err_q, ~rxd_s_q};
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          prs_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign prs_en        = prs_en_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: drives serial frames into an 8N1 and an 8E1 instance,
// each fed by a behavioural prescaler, and checks delivered beats against a frame model.
module tb_uart_rx_sequencer;

  localparam int DIV = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] user;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      rxd;
  logic [1:0]      prsEn;
  logic [1:0]      prsHalf;
  logic [1:0]      tready;
  logic [1:0]      tvalid;
  logic [1:0]      overrun;
  logic [1:0][7:0] tdata;
  logic [1:0][1:0] tuser;

  int vectors     = 0;
  int miscompares = 0;

  int    cyc         = 0;
  int    halfCnt[2]  = '{0, 0};
  int    lastHalf[2] = '{0, 0};
  int    ovCnt[2]    = '{0, 0};
  int    riseCyc[2]  = '{0, 0};
  logic [1:0] tvalidPrev = 2'b00;
  beat_t q0[$];
  beat_t q1[$];

  always #5 clk = ~clk;

  uart_rx_sequencer #(.DATA_BITS(8), .PARITY(0)) dutN (
    .clk(clk), .rst(rst), .rxd(rxd[0]), .prs_en(prsEn[0]), .prs_half(prsHalf[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
    .m_axis_tuser(tuser[0]), .overrun(overrun[0])
  );

  uart_rx_sequencer #(.DATA_BITS(8), .PARITY(2)) dutE (
    .clk(clk), .rst(rst), .rxd(rxd[1]), .prs_en(prsEn[1]), .prs_half(prsHalf[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
    .m_axis_tuser(tuser[1]), .overrun(overrun[1])
  );

  // Behavioural prescaler: counter clears while disabled, strobes once mid-period.
  for (genvar g = 0; g < 2; g++) begin : gPres
    int cnt;
    always @(posedge clk or posedge rst) begin
      if (rst) cnt <= 0;
      else if (!prsEn[g]) cnt <= 0;
      else cnt <= (cnt == DIV - 1) ? 0 : cnt + 1;
    end
    assign prsHalf[g] = prsEn[g] && (cnt == DIV / 2 - 1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: logs strobes, overruns, tvalid rises and accepted beats.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (prsHalf[u]) begin
        halfCnt[u]  <= halfCnt[u] + 1;
        lastHalf[u] <= cyc;
      end
      if (overrun[u]) ovCnt[u] <= ovCnt[u] + 1;
      if (tvalid[u] && !tvalidPrev[u]) riseCyc[u] <= cyc;
      if (tvalid[u] && tready[u]) begin
        if (u == 0) q0.push_back({tdata[u], tuser[u]});
        else        q1.push_back({tdata[u], tuser[u]});
      end
    end
    tvalidPrev <= tvalid;
  end

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  // Reference for tuser: even-parity instance flags an odd count of ones over data+parity.
  function automatic logic [1:0] modelUser(input int u, input logic [7:0] d,
                                           input bit parBit, input bit stopBit);
    logic parErr;
    parErr = (u == 1) ? ((^d) ^ parBit) : 1'b0;
    return {parErr, ~stopBit};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input int u, input bit v);
    rxd[u] = v;
    ticks(DIV);
  endtask

  task automatic applyStimulus(input int u, input logic [7:0] data, input bit withPar,
                               input bit parBit, input bit stopBit, input bit idleAfter);
    sendBit(u, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(u, data[i]);
    if (withPar) sendBit(u, parBit);
    sendBit(u, stopBit);
    if (idleAfter) sendBit(u, 1'b1);
  endtask

  task automatic expectBeat(input int u, input logic [7:0] expData, input logic [1:0] expUser,
                            input string tag);
    int n;
    beat_t b;
    n = 0;
    while (qsize(u) == 0 && n < 4 * DIV) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({tag, "_beat_present"}, 32'(qsize(u) != 0), 32'd1);
    if (qsize(u) != 0) begin
      b = (u == 0) ? q0.pop_front() : q1.pop_front();
      checkOutput({tag, "_tdata"}, 32'(b.data), 32'(expData));
      checkOutput({tag, "_tuser"}, 32'(b.user), 32'(expUser));
    end
  endtask

  initial begin
    int h;
    int ov;
    logic [7:0] d;
    bit pb, sb;
    rst = 1'b1;
    rxd = 2'b11;
    tready = 2'b11;
    ticks(3);

    $display("[TB] reset values");
    for (int u = 0; u < 2; u++) begin
      checkOutput("rst_prs_en", 32'(prsEn[u]), 32'd0);
      checkOutput("rst_tvalid", 32'(tvalid[u]), 32'd0);
      checkOutput("rst_tdata", 32'(tdata[u]), 32'd0);
      checkOutput("rst_tuser", 32'(tuser[u]), 32'd0);
      checkOutput("rst_overrun", 32'(overrun[u]), 32'd0);
    end
    rst = 1'b0;
    ticks(4);

    $display("[TB] 8N1 0xA5");
    h = halfCnt[0];
    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    expectBeat(0, 8'hA5, 2'b00, "a5");
    checkOutput("a5_latency", 32'(riseCyc[0] - lastHalf[0]), 32'd1);
    checkOutput("a5_half_count", 32'(halfCnt[0] - h), 32'd10);
    checkOutput("a5_prs_en_low", 32'(prsEn[0]), 32'd0);
    checkOutput("a5_tvalid_low", 32'(tvalid[0]), 32'd0);

    $display("[TB] start glitch");
    h = halfCnt[0];
    rxd[0] = 1'b0;
    ticks(3);
    rxd[0] = 1'b1;
    checkOutput("glitch_prs_en_high", 32'(prsEn[0]), 32'd1);
    ticks(3 * DIV);
    checkOutput("glitch_half_count", 32'(halfCnt[0] - h), 32'd1);
    checkOutput("glitch_prs_en_low", 32'(prsEn[0]), 32'd0);
    checkOutput("glitch_no_beat", 32'(qsize(0)), 32'd0);

    $display("[TB] framing error, line held low");
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    expectBeat(0, 8'h3C, 2'b01, "frm");
    h = halfCnt[0];
    ticks(4 * DIV);
    checkOutput("frm_hold_no_strobe", 32'(halfCnt[0] - h), 32'd0);
    checkOutput("frm_hold_prs_en", 32'(prsEn[0]), 32'd0);
    checkOutput("frm_hold_no_beat", 32'(qsize(0)), 32'd0);
    sendBit(0, 1'b1);
    applyStimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    expectBeat(0, 8'h5A, 2'b00, "frm_recover");

    $display("[TB] even parity");
    h = halfCnt[1];
    applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    expectBeat(1, 8'h07, 2'b10, "par_bad");
    checkOutput("par_half_count", 32'(halfCnt[1] - h), 32'd11);
    checkOutput("par_latency", 32'(riseCyc[1] - lastHalf[1]), 32'd1);
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    expectBeat(1, 8'h07, 2'b00, "par_good");

    $display("[TB] overrun");
    tready[0] = 1'b0;
    ov = ovCnt[0];
    applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_first_tvalid", 32'(tvalid[0]), 32'd1);
    checkOutput("ovr_first_tdata", 32'(tdata[0]), 32'h11);
    checkOutput("ovr_first_no_pulse", 32'(ovCnt[0] - ov), 32'd0);
    applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_pulse_count", 32'(ovCnt[0] - ov), 32'd1);
    checkOutput("ovr_held_tdata", 32'(tdata[0]), 32'h11);
    checkOutput("ovr_held_tuser", 32'(tuser[0]), 32'd0);
    checkOutput("ovr_held_tvalid", 32'(tvalid[0]), 32'd1);
    checkOutput("ovr_no_beat_yet", 32'(qsize(0)), 32'd0);
    tready[0] = 1'b1;
    expectBeat(0, 8'h11, 2'b00, "ovr_drain");
    ticks(3 * DIV);
    checkOutput("ovr_single_beat", 32'(qsize(0)), 32'd0);
    checkOutput("ovr_tvalid_low", 32'(tvalid[0]), 32'd0);

    $display("[TB] reset mid-frame");
    tready[0] = 1'b0;
    applyStimulus(0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
    sendBit(0, 1'b0);
    sendBit(0, 1'b1);
    sendBit(0, 1'b0);
    sendBit(0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_prs_en", 32'(prsEn[0]), 32'd0);
    checkOutput("midrst_tvalid", 32'(tvalid[0]), 32'd0);
    checkOutput("midrst_tdata", 32'(tdata[0]), 32'd0);
    checkOutput("midrst_tuser", 32'(tuser[0]), 32'd0);
    rxd[0] = 1'b1;
    ticks(2);
    rst = 1'b0;
    tready[0] = 1'b1;
    ticks(DIV);
    applyStimulus(0, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
    expectBeat(0, 8'h66, 2'b00, "midrst_66");
    ticks(2 * DIV);
    checkOutput("midrst_only_one_beat", 32'(qsize(0)), 32'd0);

    $display("[TB] random frames");
    for (int i = 0; i < 24; i++) begin
      int u;
      u = i % 2;
      d = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      applyStimulus(u, d, (u == 1), pb, sb, 1'b1);
      expectBeat(u, d, modelUser(u, d, pb, sb), "rand");
    end
    checkOutput("rand_no_extra_n", 32'(qsize(0)), 32'd0);
    checkOutput("rand_no_extra_e", 32'(qsize(1)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
